// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: aligns core memory accesses onto a word-wide
// valid/ready bus, stalls the core until completion, and extends load data.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        MemWrite,
  input  logic [3:0]  byteEnable,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        misalign,
  output logic        bus_error,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          mis_q, err_q;
  logic [31:0]   rdata_q;

  logic [1:0]    off;
  logic [3:0]    mask;
  logic          bad;
  logic [31:0]   sh, ext;

  assign off = ALUResult[1:0];

  // Lane mask at offset 0 plus misalignment/illegality check of the new request
  always_comb begin
    mask = 4'b0000;
    bad  = 1'b0;
    if (MemWrite) begin
      mask = byteEnable;
      case (byteEnable)
        4'b0001: bad = 1'b0;
        4'b0011: bad = off[0];
        4'b1111: bad = |off;
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: mask = 4'b0001;
        3'b001, 3'b101: begin mask = 4'b0011; bad = off[0]; end
        3'b010:         begin mask = 4'b1111; bad = |off;   end
        default:        bad = 1'b1;
      endcase
    end
  end

  assign sh = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ext = {24'b0, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ext = {16'b0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (mem_req) begin
          bus_we    <= MemWrite;
          bus_addr  <= {ALUResult[31:2], 2'b00};
          bus_be    <= mask << off;
          bus_wdata <= MemWrite ? (WriteData << {off, 3'b000}) : 32'h0;
          off_q     <= off;
          f3_q      <= funct3;
          mis_q     <= bad;
          err_q     <= 1'b0;
          rdata_q   <= '0;
          cnt       <= '0;
          state     <= bad ? DONE : ISSUE;
        end
        ISSUE: begin
          // Ready on the last allowed cycle still wins over the timeout
          if (bus_ready) begin
            if (!bus_we) rdata_q <= ext;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_valid = (state == ISSUE);
  assign stall     = mem_req & (state != DONE);
  assign misalign  = (state == DONE) & mis_q;
  assign bus_error = (state == DONE) & err_q;
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl with TIMEOUT=4: alignment, extension,
// misalignment, timeout boundary and asynchronous reset mid-transaction.
module tb_lsu_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, MemWrite, bus_ready;
  logic [3:0]  byteEnable;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, bus_rdata;
  logic [31:0] ReadData, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall, misalign, bus_error, bus_valid, bus_we;

  int tests = 0;
  int fails = 0;

  lsu_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .MemWrite(MemWrite),
    .byteEnable(byteEnable), .funct3(funct3), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .stall(stall),
    .misalign(misalign), .bus_error(bus_error), .bus_valid(bus_valid),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access; ready is given on the k-th ISSUE cycle (k=0: never).
  // Returns on the IDLE cycle after DONE with mem_req dropped.
  task automatic access(input logic we, input logic [3:0] be, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int k, output int vcyc, output int scyc,
                        output logic [31:0] rdat, output logic mis, output logic err,
                        output logic [31:0] baddr, output logic [3:0] bbe,
                        output logic [31:0] bwd);
    logic done;
    @(negedge clk);
    mem_req = 1'b1; MemWrite = we; byteEnable = be; funct3 = f3;
    ALUResult = a; WriteData = wd; bus_rdata = rd; bus_ready = 1'b0;
    vcyc = 0; scyc = 0; rdat = 'x; mis = 1'bx; err = 1'bx;
    baddr = '0; bbe = '0; bwd = '0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) begin
        rdat = ReadData; mis = misalign; err = bus_error; done = 1'b1;
        chk("valid_low_in_done", {31'b0, bus_valid}, 32'd0);
        break;
      end
      scyc++;
      if (bus_valid) begin
        vcyc++;
        baddr = bus_addr; bbe = bus_be; bwd = bus_wdata;
        chk("bus_we", {31'b0, bus_we}, {31'b0, we});
        bus_ready = (vcyc == k);
      end else begin
        bus_ready = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_reached", {31'b0, done}, 32'd1);
    mem_req = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    #1;
  endtask

  int v, s;
  logic [31:0] rdat, ba, bw;
  logic [3:0] bb;
  logic mis, err;

  initial begin
    reset = 1'b0; mem_req = 1'b0; MemWrite = 1'b0; bus_ready = 1'b0;
    byteEnable = 4'b0; funct3 = 3'b0; ALUResult = '0; WriteData = '0; bus_rdata = '0;
    #3;
    chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_flags", {30'b0, misalign, bus_error}, 32'd0);
    mem_req = 1'b1; #1;
    chk("rst_stall_follows_req", {31'b0, stall}, 32'd1);
    mem_req = 1'b0; #1;
    chk("rst_stall_idle", {31'b0, stall}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // bus_ready with nothing pending is ignored
    bus_ready = 1'b1;
    @(negedge clk); #1;
    chk("idle_ready_ignored", {30'b0, bus_valid, stall}, 32'd0);
    bus_ready = 1'b0;

    access(1'b1, 4'b1111, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("sw_addr", ba, 32'h100);
    chk("sw_be", {28'b0, bb}, 32'hF);
    chk("sw_wdata", bw, 32'hDEADBEEF);
    chk("sw_stall_cycles", s, 2);
    chk("sw_readdata", rdat, 32'h0);

    access(1'b1, 4'b0001, 3'b000, 32'h203, 32'h000000A5, 32'h0, 2, v, s, rdat, mis, err, ba, bb, bw);
    chk("sb_addr", ba, 32'h200);
    chk("sb_be", {28'b0, bb}, 32'h8);
    chk("sb_wdata", bw, 32'hA5000000);
    chk("sb_valid_cycles", v, 2);
    chk("sb_stall_cycles", s, 3);

    access(1'b0, 4'b0000, 3'b000, 32'h301, 32'h0, 32'h00008000, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("lb_readdata", rdat, 32'hFFFFFF80);
    chk("lb_be", {28'b0, bb}, 32'h2);
    chk("lb_addr", ba, 32'h300);

    access(1'b0, 4'b0000, 3'b100, 32'h301, 32'h0, 32'h00008000, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("lbu_readdata", rdat, 32'h00000080);

    access(1'b0, 4'b0000, 3'b101, 32'h302, 32'h0, 32'hFFEE0000, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("lhu_readdata", rdat, 32'h0000FFEE);
    chk("lhu_be", {28'b0, bb}, 32'hC);

    access(1'b0, 4'b0000, 3'b001, 32'h302, 32'h0, 32'h80010000, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("lh_readdata", rdat, 32'hFFFF8001);

    access(1'b0, 4'b0000, 3'b010, 32'h404, 32'h0, 32'h12345678, 3, v, s, rdat, mis, err, ba, bb, bw);
    chk("lw_readdata", rdat, 32'h12345678);
    chk("lw_stall_cycles", s, 4);

    access(1'b0, 4'b0000, 3'b010, 32'h402, 32'h0, 32'h12345678, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("mis_lw_valid_cycles", v, 0);
    chk("mis_lw_stall_cycles", s, 1);
    chk("mis_lw_flag", {31'b0, mis}, 32'd1);
    chk("mis_lw_readdata", rdat, 32'h0);
    chk("mis_pulse_one_cycle", {31'b0, misalign}, 32'd0);

    access(1'b1, 4'b0011, 3'b001, 32'h201, 32'h1234, 32'h0, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("mis_sh_flag", {31'b0, mis}, 32'd1);
    chk("mis_sh_valid_cycles", v, 0);

    access(1'b0, 4'b0000, 3'b011, 32'h400, 32'h0, 32'h0, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("ill_load_flag", {31'b0, mis}, 32'd1);

    access(1'b1, 4'b0111, 3'b000, 32'h400, 32'h0, 32'h0, 1, v, s, rdat, mis, err, ba, bb, bw);
    chk("ill_store_flag", {31'b0, mis}, 32'd1);

    access(1'b0, 4'b0000, 3'b010, 32'h600, 32'h0, 32'hFFFFFFFF, 0, v, s, rdat, mis, err, ba, bb, bw);
    chk("to_valid_cycles", v, 4);
    chk("to_stall_cycles", s, 5);
    chk("to_error", {31'b0, err}, 32'd1);
    chk("to_misalign", {31'b0, mis}, 32'd0);
    chk("to_readdata", rdat, 32'h0);
    chk("to_pulse_one_cycle", {31'b0, bus_error}, 32'd0);

    access(1'b0, 4'b0000, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 4, v, s, rdat, mis, err, ba, bb, bw);
    chk("edge_valid_cycles", v, 4);
    chk("edge_error", {31'b0, err}, 32'd0);
    chk("edge_readdata", rdat, 32'hCAFEF00D);

    // Reset asserted during the second ISSUE cycle
    @(negedge clk);
    mem_req = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h500; bus_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_issue1", {31'b0, bus_valid}, 32'd1);
    @(negedge clk); #1;
    chk("rst_mid_issue2", {31'b0, bus_valid}, 32'd1);
    reset = 1'b0; #1;
    chk("rst_mid_valid_drop", {31'b0, bus_valid}, 32'd0);
    chk("rst_mid_addr", bus_addr, 32'h0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd1);
    mem_req = 1'b0;
    @(negedge clk); reset = 1'b1;

    access(1'b0, 4'b0000, 3'b010, 32'h504, 32'h0, 32'h0BADF00D, 2, v, s, rdat, mis, err, ba, bb, bw);
    chk("post_rst_lw_readdata", rdat, 32'h0BADF00D);
    chk("post_rst_lw_stall", s, 3);
    chk("post_rst_lw_addr", ba, 32'h504);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
